// File: rtl/kyber_pkg.sv
// kyber_pkg: constants shared by the Kyber Parse front end.
//   Q        modulus and rejection bound for sampled coefficients
//   N_COEF   coefficients per polynomial
//   BW_COEF  coefficient width
//   state_t  FSM encoding of the parser
//   split_group() turns three stream bytes into two 12-bit candidates
package kyber_pkg;

  localparam int Q       = 3329;
  localparam int N_COEF  = 256;
  localparam int BW_COEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Returns {d2, d1}: d1 = b0 | b1[3:0]<<8, d2 = b1[7:4] | b2<<4
  function automatic logic [23:0] split_group(
    input logic [7:0] b0,
    input logic [7:0] b1,
    input logic [7:0] b2
  );
    return {b2, b1[7:4], b1[3:0], b0};
  endfunction

endpackage

// File: rtl/_xof_coef_fifo.sv
// _xof_coef_fifo: 4-entry coefficient FIFO that takes up to two pushes per
// cycle and presents its head from registers.
//   clk, rst          clock, synchronous active-high reset
//   flush             synchronous clear of all entries
//   push_cnt          number of entries written this cycle (0..2)
//   push_d0, push_d1  data for the first / second pushed entry
//   pop               remove the head entry (ignored when empty)
//   head, head_valid  current head entry and its valid flag
//   free              number of empty slots
module _xof_coef_fifo
  import kyber_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [1:0]   push_cnt,
  input  logic [W-1:0] push_d0,
  input  logic [W-1:0] push_d1,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         head_valid,
  output logic [2:0]   free
);

  localparam int DEPTH = 4;

  logic [W-1:0] mem_r [DEPTH];
  logic [1:0]   rd_ptr_r;
  logic [1:0]   wr_ptr_r;
  logic [2:0]   cnt_r;
  logic         pop_s;

  assign pop_s      = pop && (cnt_r != 3'd0);
  assign head       = mem_r[rd_ptr_r];
  assign head_valid = (cnt_r != 3'd0);
  assign free       = 3'd4 - cnt_r;

  // Storage, pointers and occupancy; the caller guarantees room for push_cnt
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      rd_ptr_r <= 2'd0;
      wr_ptr_r <= 2'd0;
      cnt_r    <= 3'd0;
    end else begin
      if (push_cnt != 2'd0) begin
        mem_r[wr_ptr_r] <= push_d0;
      end
      if (push_cnt == 2'd2) begin
        mem_r[wr_ptr_r + 2'd1] <= push_d1;
      end
      wr_ptr_r <= wr_ptr_r + push_cnt;
      rd_ptr_r <= rd_ptr_r + {1'b0, pop_s};
      cnt_r    <= cnt_r + {1'b0, push_cnt} - {2'b00, pop_s};
    end
  end

endmodule

// File: rtl/_xof_parse.sv
// _xof_parse: Kyber Parse / SampleNTT rejection sampler. Consumes XOF words
// into a two-word byte buffer, splits every 3 bytes into two 12-bit
// candidates, keeps those below Q and emits N_COEF coefficients with index.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             pulse: (re)start a polynomial from a clean state
//   i_data, i_valid     input word (byte 0 first) and valid
//   o_ready             input word accepted when i_valid && o_ready
//   o_coef, o_idx       accepted coefficient and its index
//   o_valid, i_ready    output handshake
//   o_done              pulse with the handshake of index N_COEF-1
//   o_busy              polynomial in progress
module _xof_parse
  import kyber_pkg::*;
#(
  parameter int BW_DATA = 64,
  parameter int BW_COEF = kyber_pkg::BW_COEF,
  parameter int BW_IDX  = 8,
  parameter int N_COEF  = kyber_pkg::N_COEF,
  parameter int Q       = kyber_pkg::Q
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [BW_DATA-1:0] i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [BW_COEF-1:0] o_coef,
  output logic [BW_IDX-1:0]  o_idx,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_done,
  output logic               o_busy
);

  localparam int WORD_BYTES = BW_DATA / 8;
  localparam int BUF_BYTES  = 2 * WORD_BYTES;
  localparam int BUF_BITS   = 8 * BUF_BYTES;
  localparam int FW         = $clog2(BUF_BYTES + 1);
  localparam int CW         = BW_IDX + 1;

  localparam logic [FW-1:0]      FILL_WORD = FW'(WORD_BYTES);
  localparam logic [FW-1:0]      FILL_GRP  = FW'(3);
  localparam logic [FW-1:0]      FILL_RDY  = FW'(BUF_BYTES - WORD_BYTES);
  localparam logic [CW-1:0]      N_C       = CW'(N_COEF);
  localparam logic [BW_COEF-1:0] Q_C       = BW_COEF'(Q);

  state_t               state_r;
  state_t               state_next_s;
  logic [BUF_BITS-1:0]  buf_r;
  logic [BUF_BITS-1:0]  buf_shift_s;
  logic [BUF_BITS-1:0]  buf_next_s;
  logic [FW-1:0]        fill_r;
  logic [FW-1:0]        fill_after_s;
  logic [FW-1:0]        fill_next_s;
  logic [CW-1:0]        ins_r;
  logic [CW-1:0]        ins_next_s;
  logic [CW-1:0]        out_cnt_r;

  logic                 word_hs_s;
  logic                 out_hs_s;
  logic                 last_hs_s;
  logic                 step_s;
  logic                 acc1_s;
  logic                 acc2_s;
  logic [BW_COEF-1:0]   d1_s;
  logic [BW_COEF-1:0]   d2_s;
  logic [1:0]           push_cnt_s;
  logic [BW_COEF-1:0]   push_d0_s;
  logic [2:0]           fifo_free_s;
  logic [2:0]           avail_s;
  logic                 fifo_valid_s;
  logic [BW_COEF-1:0]   fifo_head_s;

  assign o_ready   = (state_r == ST_RUN) && (fill_r <= FILL_RDY);
  assign word_hs_s = i_valid && o_ready;
  assign out_hs_s  = fifo_valid_s && i_ready;

  // A slot freed by this cycle's pop counts as room, so the output can
  // stream one coefficient per cycle.
  assign avail_s = fifo_free_s + {2'b00, out_hs_s};
  assign step_s  = (state_r == ST_RUN) && (fill_r >= FILL_GRP) && (avail_s >= 3'd2);

  assign {d2_s, d1_s} = split_group(buf_r[7:0], buf_r[15:8], buf_r[23:16]);

  // d2 is only kept if d1 did not already complete the polynomial
  assign acc1_s = step_s && (d1_s < Q_C) && (ins_r < N_C);
  assign acc2_s = step_s && (d2_s < Q_C) &&
                  ((ins_r + {{(CW-1){1'b0}}, acc1_s}) < N_C);

  assign push_cnt_s = {1'b0, acc1_s} + {1'b0, acc2_s};
  assign push_d0_s  = acc1_s ? d1_s : d2_s;
  assign ins_next_s = ins_r + {{(CW-1){1'b0}}, acc1_s} + {{(CW-1){1'b0}}, acc2_s};

  assign last_hs_s = (state_r == ST_DRAIN) && out_hs_s && (out_cnt_r == (N_C - CW'(1)));

  assign o_coef  = fifo_head_s;
  assign o_valid = fifo_valid_s;
  assign o_idx   = out_cnt_r[BW_IDX-1:0];
  assign o_done  = last_hs_s;
  assign o_busy  = (state_r != ST_IDLE);

  // Byte buffer update: drop the consumed group, then append any new word
  // right behind the remaining bytes (bytes above fill are always zero).
  always_comb begin
    buf_shift_s  = buf_r;
    fill_after_s = fill_r;
    buf_next_s   = buf_r;
    fill_next_s  = fill_r;
    if (step_s) begin
      buf_shift_s  = buf_r >> 24;
      fill_after_s = fill_r - FILL_GRP;
    end else begin
      buf_shift_s  = buf_r;
      fill_after_s = fill_r;
    end
    if (word_hs_s) begin
      buf_next_s  = buf_shift_s | (BUF_BITS'(i_data) << {fill_after_s, 3'b000});
      fill_next_s = fill_after_s + FILL_WORD;
    end else begin
      buf_next_s  = buf_shift_s;
      fill_next_s = fill_after_s;
    end
  end

  // Next-state logic; a start pulse restarts from any state
  always_comb begin
    state_next_s = state_r;
    if (i_start) begin
      state_next_s = ST_RUN;
    end else begin
      case (state_r)
        ST_IDLE:  state_next_s = ST_IDLE;
        ST_RUN: begin
          if (ins_next_s == N_C) begin
            state_next_s = ST_DRAIN;
          end else begin
            state_next_s = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (last_hs_s) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_DRAIN;
          end
        end
        default:  state_next_s = ST_IDLE;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Buffer and counters; leftover bytes are discarded when entering DRAIN
  always_ff @(posedge i_clk) begin
    if (i_rst || i_start) begin
      buf_r     <= '0;
      fill_r    <= '0;
      ins_r     <= '0;
      out_cnt_r <= '0;
    end else begin
      if ((state_r == ST_RUN) && (state_next_s == ST_DRAIN)) begin
        buf_r  <= '0;
        fill_r <= '0;
      end else begin
        buf_r  <= buf_next_s;
        fill_r <= fill_next_s;
      end
      ins_r     <= ins_next_s;
      out_cnt_r <= out_cnt_r + {{(CW-1){1'b0}}, out_hs_s};
    end
  end

  _xof_coef_fifo #(
    .W (BW_COEF)
  ) u_fifo (
    .clk        (i_clk),
    .rst        (i_rst),
    .flush      (i_start),
    .push_cnt   (push_cnt_s),
    .push_d0    (push_d0_s),
    .push_d1    (d2_s),
    .pop        (out_hs_s),
    .head       (fifo_head_s),
    .head_valid (fifo_valid_s),
    .free       (fifo_free_s)
  );

endmodule

// File: tb/tb__xof_parse.sv
// tb__xof_parse: self-checking bench for _xof_parse (BW_DATA = 64).
// Each scenario task drives a stream and checks the recorded outputs against
// a reference Parse computed from the bytes the DUT actually accepted.
module tb__xof_parse;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] data;
  logic        valid;
  logic        o_ready;
  logic [11:0] o_coef;
  logic [7:0]  o_idx;
  logic        o_valid;
  logic        dn_ready;
  logic        o_done;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  byte unsigned acc_bytes[$];
  int exp_q[$];
  int out_coef[$];
  int out_idx[$];
  int done_idx[$];
  bit tr_valid[$];
  bit tr_oready[$];
  int tr_coef[$];
  int tr_idx[$];
  int words;
  bit timed_out;

  _xof_parse dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_data  (data),
    .i_valid (valid),
    .o_ready (o_ready),
    .o_coef  (o_coef),
    .o_idx   (o_idx),
    .o_valid (o_valid),
    .i_ready (dn_ready),
    .o_done  (o_done),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference Parse over the accepted byte stream
  task automatic build_model();
    exp_q.delete();
    for (int i = 0; i + 2 < acc_bytes.size(); i += 3) begin
      int b0 = acc_bytes[i];
      int b1 = acc_bytes[i+1];
      int b2 = acc_bytes[i+2];
      int d1 = b0 + (b1 % 16) * 256;
      int d2 = (b1 / 16) + b2 * 16;
      if (exp_q.size() < 256 && d1 < 3329) exp_q.push_back(d1);
      if (exp_q.size() < 256 && d2 < 3329) exp_q.push_back(d2);
    end
  endtask

  function automatic logic [63:0] gen_word(input int mode, input logic [63:0] pat, input bit first);
    case (mode)
      0: return {$urandom, $urandom};
      1: return 64'h0;
      2: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return first ? pat : 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Start a polynomial and stream words; records per-cycle trace and handshakes.
  // rdy_mode: 0 always ready, 1 random, 2 stalled for cycles 40..49.
  task automatic run_stream(input int mode, input logic [63:0] pat, input int rdy_mode,
                            input int vld_mode, input int max_cyc, input int stop_idx);
    logic [63:0] cur;
    int cyc = 0;
    int tail = -1;
    acc_bytes.delete(); out_coef.delete(); out_idx.delete(); done_idx.delete();
    tr_valid.delete(); tr_oready.delete(); tr_coef.delete(); tr_idx.delete();
    words = 0;
    timed_out = 0;
    @(negedge clk);
    start = 1'b1; valid = 1'b0; dn_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cur = gen_word(mode, pat, 1'b1);
    while (1) begin
      valid = (vld_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      data  = cur;
      case (rdy_mode)
        0: dn_ready = 1'b1;
        1: dn_ready = ($urandom_range(0, 3) != 0);
        default: dn_ready = !(cyc >= 40 && cyc < 50);
      endcase
      #1;
      tr_valid.push_back(o_valid); tr_oready.push_back(o_ready);
      tr_coef.push_back(o_coef);   tr_idx.push_back(o_idx);
      if (valid && o_ready) begin
        for (int k = 0; k < 8; k++) acc_bytes.push_back(cur[8*k +: 8]);
        words++;
        cur = gen_word(mode, pat, 1'b0);
      end
      if (o_valid && dn_ready) begin
        out_coef.push_back(o_coef);
        out_idx.push_back(o_idx);
        if (o_done) done_idx.push_back(o_idx);
      end else if (o_done) begin
        done_idx.push_back(-1);
      end
      if (stop_idx >= 0 && o_valid && dn_ready && int'(o_idx) == stop_idx) break;
      if (o_done && tail < 0) tail = 20;
      cyc++;
      if (tail == 0) break;
      if (tail > 0) tail--;
      if (cyc >= max_cyc) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clk);
    end
    build_model();
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", o_ready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_coef !== 12'd0) begin errors++; $display("FAIL reset_coef: got %0d want 0", o_coef); end
    checks++; if (o_idx !== 8'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", o_idx); end
    checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", o_done); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reject_d1();
    // bytes 01 0D 0D: d1 = 3329 rejected, d2 = 208 accepted; rest 0xFF rejects
    run_stream(3, 64'hFFFF_FFFF_FF0D_0D01, 0, 0, 60, -1);
    checks++; if (out_coef.size() != 1) begin errors++; $display("FAIL rej_count: got %0d want 1", out_coef.size()); end
    if (out_coef.size() >= 1) begin
      checks++; if (out_coef[0] != 208) begin errors++; $display("FAIL rej_coef: got %0d want 208", out_coef[0]); end
      checks++; if (out_idx[0] != 0) begin errors++; $display("FAIL rej_idx: got %0d want 0", out_idx[0]); end
    end
  endtask

  task automatic test_d1_boundary();
    // bytes 00 0D 00: d1 = 3328 and d2 = 0, both accepted in order
    run_stream(3, 64'hFFFF_FFFF_FF00_0D00, 0, 0, 60, -1);
    checks++; if (out_coef.size() != 2) begin errors++; $display("FAIL bnd_count: got %0d want 2", out_coef.size()); end
    if (out_coef.size() >= 2) begin
      checks++; if (out_coef[0] != 3328 || out_idx[0] != 0) begin errors++; $display("FAIL bnd_first: got %0d@%0d want 3328@0", out_coef[0], out_idx[0]); end
      checks++; if (out_coef[1] != 0 || out_idx[1] != 1) begin errors++; $display("FAIL bnd_second: got %0d@%0d want 0@1", out_coef[1], out_idx[1]); end
    end
  endtask

  task automatic test_all_zero();
    int bad = 0;
    run_stream(1, 64'h0, 0, 0, 2000, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL zero_timeout: got no done want done"); end
    checks++; if (out_coef.size() != 256) begin errors++; $display("FAIL zero_count: got %0d want 256", out_coef.size()); end
    for (int k = 0; k < out_coef.size(); k++) begin
      if (out_coef[k] != 0 || out_idx[k] != k) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL zero_values: got %0d bad outputs want 0", bad); end
    checks++; if (done_idx.size() != 1 || (done_idx.size() == 1 && done_idx[0] != 255)) begin
      errors++; $display("FAIL zero_done: got %0d pulses want 1 at idx 255", done_idx.size()); end
    // 384 bytes are needed; the two-word buffer may admit up to two extra words
    checks++; if (words < 48 || words > 50) begin errors++; $display("FAIL zero_words: got %0d want 48..50", words); end
    checks++; if (tr_oready[tr_oready.size()-1] !== 1'b0 || tr_valid[tr_valid.size()-1] !== 1'b0) begin
      errors++; $display("FAIL zero_after_done: got ready=%b valid=%b want 0 0", tr_oready[tr_oready.size()-1], tr_valid[tr_valid.size()-1]); end
  endtask

  task automatic test_all_ff();
    int lows = 0;
    int highs = 0;
    run_stream(2, 64'h0, 0, 0, 200, -1);
    checks++; if (out_coef.size() != 0) begin errors++; $display("FAIL ff_outputs: got %0d want 0", out_coef.size()); end
    for (int c = 150; c < tr_oready.size(); c++) begin
      if (tr_oready[c]) highs++; else lows++;
    end
    checks++; if (lows == 0 || highs == 0) begin errors++; $display("FAIL ff_ready_cycling: got %0d high %0d low want both >0", highs, lows); end
    checks++; if (words < 50) begin errors++; $display("FAIL ff_words: got %0d want >=50", words); end
  endtask

  task automatic test_random_full();
    int bad = 0;
    run_stream(0, 64'h0, 1, 1, 4000, -1);
    checks++; if (timed_out) begin errors++; $display("FAIL rnd_timeout: got no done want done"); end
    checks++; if (out_coef.size() != 256 || exp_q.size() != 256) begin
      errors++; $display("FAIL rnd_count: got %0d want 256 (model %0d)", out_coef.size(), exp_q.size()); end
    for (int k = 0; k < out_coef.size() && k < exp_q.size(); k++) begin
      if (out_coef[k] != exp_q[k] || out_idx[k] != k) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rnd_values: got %0d bad outputs want 0", bad); end
    checks++; if (out_idx.size() == 0 || out_idx[0] != 0) begin errors++; $display("FAIL rnd_restart_idx: first idx not 0"); end
    checks++; if (done_idx.size() != 1 || (done_idx.size() == 1 && done_idx[0] != 255)) begin
      errors++; $display("FAIL rnd_done: got %0d pulses want 1 at idx 255", done_idx.size()); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    int holds = 0;
    bit fell = 1'b0;
    run_stream(0, 64'h0, 2, 0, 3000, -1);
    checks++; if (tr_valid.size() < 51 || tr_valid[40] !== 1'b1) begin errors++; $display("FAIL bp_midstream: no valid output at stall start"); end
    for (int c = 41; c < 50 && c < tr_valid.size(); c++) begin
      if (tr_valid[c-1] && (!tr_valid[c] || tr_coef[c] != tr_coef[c-1] || tr_idx[c] != tr_idx[c-1])) holds++;
      if (!tr_oready[c]) fell = 1'b1;
    end
    checks++; if (holds != 0) begin errors++; $display("FAIL bp_hold: got %0d changes want 0", holds); end
    checks++; if (!fell) begin errors++; $display("FAIL bp_ready_fall: got ready high throughout want low"); end
    checks++; if (out_coef.size() != 256 || exp_q.size() != 256) begin
      errors++; $display("FAIL bp_count: got %0d want 256 (model %0d)", out_coef.size(), exp_q.size()); end
    for (int k = 0; k < out_coef.size() && k < exp_q.size(); k++) begin
      if (out_coef[k] != exp_q[k] || out_idx[k] != k) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_values: got %0d bad outputs want 0", bad); end
  endtask

  task automatic test_reset_mid();
    run_stream(1, 64'h0, 0, 0, 2000, 100);
    checks++; if (timed_out || out_idx.size() == 0 || out_idx[out_idx.size()-1] != 100) begin
      errors++; $display("FAIL mid_reach100: got timeout=%b want idx 100 reached", timed_out); end
    @(posedge clk);
    #1;
    rst = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_ready !== 1'b0 || o_valid !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_flags: got rdy=%b vld=%b done=%b busy=%b want 0", o_ready, o_valid, o_done, o_busy); end
    checks++; if (o_coef !== 12'd0 || o_idx !== 8'd0) begin
      errors++; $display("FAIL mid_reset_data: got coef=%0d idx=%0d want 0 0", o_coef, o_idx); end
    rst = 1'b0;
    run_stream(1, 64'h0, 0, 0, 2000, -1);
    checks++; if (out_idx.size() != 256 || out_idx[0] != 0 || out_idx[255] != 255) begin
      errors++; $display("FAIL mid_restart: got %0d outputs want 256 from idx 0", out_idx.size()); end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; start = 1'b0; data = 64'h0; valid = 1'b0; dn_ready = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    test_reject_d1();
    test_d1_boundary();
    test_all_zero();
    test_all_ff();
    test_random_full();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
